spi_reg_writer: RTL
===================

# spi_reg_writer

SPI mode-0 controller that serialises register-write requests into 16-bit frames. It drives the SCLK/COPI/nCS lines of the on-chip SPI peripheral that owns the data0..data4 configuration registers, and serves as the bench and host-side driver for that register bank. It takes one write per valid/ready handshake, generates a slow SCLK from the system clock, and signals completion with a one-cycle pulse.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range ≥3, because the peripheral resynchronises its inputs through three flops.
- GAP_CYCLES, 8: minimum nCS-high time between frames, in clk cycles; legal range ≥4.
- MAX_ADDR, 4: highest implemented peripheral register address.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- req_valid  in  1  write request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  7  register address.
- req_data  in  8  register value.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse when an address is rejected (only with the macro).
- SCLK  out  1  SPI clock, idle low.
- COPI  out  1  serial data, MSB first.
- nCS  out  1  chip select, active low.

## Operation
- Frame is 16 bits, MSB first: bit15 = 1 (write), bits14:8 = req_addr, bits7:0 = req_data.
- A request is accepted on a clk edge where req_valid && req_ready. The controller captures the frame into a 16-bit shift register.
- req_valid while busy is ignored and is not queued.
- State machine:
  - IDLE: req_ready=1. On accept → LEAD.
  - LEAD: nCS=0, COPI=bit15, SCLK=0 for CLK_DIV cycles → HIGH.
  - HIGH: SCLK=1 for CLK_DIV cycles → LOW.
  - LOW: SCLK=0 for CLK_DIV cycles. At entry to LOW, COPI shifts to the next bit unless this is the 16th bit. After 16 HIGH phases → GAP; otherwise → HIGH.
  - GAP: nCS=1, COPI=0. done=1 in the first GAP cycle. Stays for GAP_CYCLES cycles → IDLE.
- COPI changes only while SCLK is low and is stable across every rising edge.
- The peripheral commits the data on the nCS rising edge, so done marks the commit point.
- Bit counter is 5 bits (0..16). The half-period counter is $clog2(CLK_DIV) bits and reloads at every phase change.

## Timing
- Reset values: SCLK=0, COPI=0, nCS=1, req_ready=1, done=0, err=0; state IDLE.
- Accept at edge T0 → nCS falls at T0+1.
- SCLK rising edge k (k=1..16) occurs at T0+1+(2k−1)·CLK_DIV.
- nCS low for exactly 33·CLK_DIV cycles.
- done pulses in the cycle nCS rises. req_ready returns GAP_CYCLES cycles later.
- Request-to-request period: 33·CLK_DIV+GAP_CYCLES+1 cycles (LEAD + 16 HIGH/LOW pairs + GAP + the IDLE accept cycle).
- Reset asserted mid-frame: at the next edge all outputs take their reset values. nCS rises immediately and the aborted frame does not produce done. The peripheral may latch a partial value; this is accepted behaviour.
- req_valid in the same cycle done pulses: not accepted, because req_ready=0.

## Configuration
- SPI_REG_WRITER_ADDR_CHECK_EN defined:
  - An accepted request with req_addr > MAX_ADDR produces err=1 for one cycle after acceptance.
  - No SCLK/nCS activity occurs; the controller returns straight to IDLE, so req_ready is low for exactly one cycle.
- Macro undefined:
  - No check; err is tied 0 and every address is transmitted.

## Structure
- Package spi_reg_pkg holds:
  - FRAME_W=16, ADDR_W=7, DATA_W=8.
  - WRITE_BIT=1'b1.
  - Default MAX_ADDR.
  - The state enum (IDLE, LEAD, HIGH, LOW, GAP).
- Sub-module spi_phase_timer: loadable down-counter that emits a tick at the end of each CLK_DIV or GAP_CYCLES interval. Parent holds the FSM, shift register and bit counter.

## Test plan
- Write addr 0x00 data 0xA5, CLK_DIV=4:
  - COPI sampled at 16 SCLK rises = 0x80A5.
  - nCS low 132 cycles; done once.
  - With the peripheral connected, data0=0xA5 after done.
- Writes (0x04,0x3C) and (0x02,0xFF) with req_valid held high:
  - Second accept occurs exactly GAP_CYCLES+1 cycles after the first done.
  - data4=0x3C, data2=0xFF.
- Reset pulsed after the 5th SCLK rise:
  - Next cycle SCLK=0, nCS=1, req_ready=1, no done.
  - A following write to 0x01/0x5A completes correctly.
- req_valid toggling during a frame: no extra frames; frame count equals the number of accepts.
- With SPI_REG_WRITER_ADDR_CHECK_EN, addr 0x05 data 0x11:
  - err pulses and nCS stays 1; data registers unchanged.
  - Without the macro, COPI=0x8511 and done pulses.
- CLK_DIV=3, GAP_CYCLES=4, write 0x03/0x96: peripheral data3=0x96, which confirms the minimum-divider margin.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register writer.
// Frame layout: {write bit, 7-bit address, 8-bit data}, sent MSB first.
package spi_reg_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic WRITE_BIT = 1'b1;

  localparam int MAX_ADDR_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] mk_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_reg_writer_if.sv
// Request handshake bundle between a host and spi_reg_writer.
// master drives the request, slave answers with ready/done/err.
interface spi_reg_writer_if;
  import spi_reg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, done, err
  );

endinterface

// File: rtl/spi_reg_writer_timer.sv
// spi_phase_timer: loadable down-counter for SCLK phases and nCS gap.
// Load with N-1; o_tick is high in the last cycle of the interval.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  // Count down to zero and hold; reload wins over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 register writer: one 16-bit write frame per request.
// SPI_REG_WRITER_ADDR_CHECK_EN rejects addresses above MAX_ADDR.
module spi_reg_writer
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_ADDR   = MAX_ADDR_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_writer_if.slave bus,
  output logic           SCLK,
  output logic           nCS,
  output logic           COPI
);

  localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] HALF_LD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

  if (CLK_DIV < 3 || GAP_CYCLES < 4 || MAX_ADDR > 127) begin : g_cfg_err
    $error("spi_reg_writer: illegal parameter set");
  end

  state_t               r_state;
  logic [FRAME_W-1:0]   r_shift;
  logic [4:0]           r_bitcnt;
  logic                 r_sclk;
  logic                 r_ncs;
  logic                 r_ready;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_bad;
  logic                 w_last;
  logic                 w_tick;
  logic                 w_load;
  logic [TW-1:0]        w_load_val;
  logic [FRAME_W-1:0]   w_frame;

`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
  logic r_err;
  assign w_bad   = bus.req_addr > ADDR_W'(MAX_ADDR);
  assign bus.err = r_err;
`else
  assign w_bad   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign w_accept = bus.req_valid && r_ready && (r_state == IDLE);
  assign w_frame  = mk_frame(bus.req_addr, bus.req_data);
  assign w_last   = (r_bitcnt == 5'd16);

  assign w_load = (w_accept && !w_bad)
               || ((r_state != IDLE) && w_tick);

  assign w_load_val = ((r_state == LOW) && w_last) ? GAP_LD : HALF_LD;

  spi_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_tick (w_tick)
  );

  // Frame sequencer; COPI is the MSB of the shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_sclk   <= 1'b0;
      r_ncs    <= 1'b1;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
      r_err  <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_bad) begin
`ifdef SPI_REG_WRITER_ADDR_CHECK_EN
              r_err <= 1'b1;
`endif
            end else begin
              r_state  <= LEAD;
              r_ncs    <= 1'b0;
              r_shift  <= w_frame;
              r_bitcnt <= '0;
            end
          end
        end
        LEAD: begin
          if (w_tick) begin
            r_state <= HIGH;
            r_sclk  <= 1'b1;
          end
        end
        HIGH: begin
          if (w_tick) begin
            r_state  <= LOW;
            r_sclk   <= 1'b0;
            r_bitcnt <= r_bitcnt + 5'd1;
            if (r_bitcnt != 5'd15) begin
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
          end
        end
        LOW: begin
          if (w_tick) begin
            if (w_last) begin
              r_state <= GAP;
              r_ncs   <= 1'b1;
              r_shift <= '0;
              r_done  <= 1'b1;
            end else begin
              r_state <= HIGH;
              r_sclk  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.done      = r_done;
  assign SCLK          = r_sclk;
  assign nCS           = r_ncs;
  assign COPI          = r_shift[FRAME_W-1];

endmodule
